// File: rtl/contador_ventana_ctrl_pkg.sv
// contador_pkg: shared state encoding and default sizing for the window counter
package contador_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
    typedef enum logic [1:0] {IDLE, ARM, COUNT, HOLD} state_e;
endpackage

// File: rtl/contador_ventana_ctrl_if.sv
// contador_ventana_ctrl_if: control, event line and result handshake of the window counter
interface contador_ventana_ctrl_if
    import contador_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
);
    logic             start_i;
    logic [WIN_W-1:0] window_i;
    logic             event_i;
    logic             ready_i;
    logic             busy_o;
    logic             valid_o;
    logic [CNT_W-1:0] result_o;
    logic             overflow_o;
    modport slave (
        input  start_i, window_i, event_i, ready_i,
        output busy_o, valid_o, result_o, overflow_o
    );
    modport master (
        output start_i, window_i, event_i, ready_i,
        input  busy_o, valid_o, result_o, overflow_o
    );
endinterface

// File: rtl/contador_flanco_det.sv
// contador_flanco_det: synchronizer chain plus rising-edge pulse on an async line
module contador_flanco_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_i,
    input  logic arm_i,
    input  logic sig_i,
    output logic pulse_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    // history follows the synced level every cycle, so at ARM it already holds the current level
    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q & ~arm_i;
endmodule

// File: rtl/contador_ventana_ctrl.sv
// contador_ventana_ctrl: counts synced rising edges over a programmed window and hands the result off
module contador_ventana_ctrl
    import contador_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic                    clk,
    input logic                    rst_i,
    contador_ventana_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    state_e           state_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             busy_q;
    logic             valid_q;
    logic             pulse;
    contador_flanco_det #(.SYNC_STAGES(SYNC_STAGES)) u_flanco (
        .clk     (clk),
        .rst_i   (rst_i),
        .arm_i   (state_q == ARM),
        .sig_i   (bus.event_i),
        .pulse_o (pulse)
    );
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    state_q <= ARM;
                    win_q   <= bus.window_i;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    busy_q  <= 1'b1;
                end
                ARM: begin
                    rem_q   <= win_q;
                    state_q <= (win_q == '0) ? HOLD : COUNT;
                    busy_q  <= win_q != '0;
                    valid_q <= win_q == '0;
                end
                COUNT: begin
                    // a pulse arriving at full scale is lost, which is what overflow reports
                    if (pulse && cnt_q == CNT_SAT) ovf_q <= 1'b1;
                    else if (pulse) cnt_q <= cnt_q + 1'b1;
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == 1) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: if (bus.ready_i) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.busy_o     = busy_q;
    assign bus.valid_o    = valid_q;
    assign bus.result_o   = cnt_q;
    assign bus.overflow_o = ovf_q;
endmodule
